sad_pixel_mem: RTL and testbench

Pixel-array responder for the `sad` core. Stores two pixel blocks, A and B, loaded from a streaming load port. Serves `A_data`/`B_data` to the core on its `AB_addr`/`AB_rd` read port, and issues the core's `go` pulse once both blocks are present. It replaces the behavioural pixel memory and sequences one SAD computation per load.

---
 rtl/sad_pkg.sv | 14 +
 rtl/sad_pix_bank.sv | 89 ++++++++
 rtl/sad_pixel_mem.sv | 133 +++++++++++++
 tb/tb_sad_pixel_mem.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared types and constants for the sad pixel memory.
// Holds the controller state enum and default geometry.
package sad_pkg;

    typedef enum logic [1:0] {
        S_LOAD,
        S_ARM,
        S_SERVE
    } sad_mem_state_t;

    localparam int SAD_DEPTH = 256;
    localparam int SAD_PIX_W = 9;

endpackage

// File: rtl/sad_pix_bank.sv
// One pixel block: storage, fill pointer, latched length,
// loaded flag and a length/range-gated read port.
module sad_pix_bank
    import sad_pkg::*;
#(
    parameter int DATA_W = SAD_PIX_W,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = SAD_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_last_i,
    input  logic              clr_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              loaded_o,
    output logic              loaded_nxt_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [LW-1:0]     len_q, len_d;
    logic              loaded_q, loaded_d;
    logic              wr_ok;
    logic              fill_end;

    // A full block refuses further beats even if the steering misbehaves.
    assign wr_ok = wr_en_i && !loaded_q;

    // Fill bookkeeping: advance pointer, close the block on last beat.
    always_comb begin
        wptr_d   = wptr_q;
        len_d    = len_q;
        loaded_d = loaded_q;
        fill_end = 1'b0;
        if (clr_i) begin
            wptr_d   = '0;
            len_d    = '0;
            loaded_d = 1'b0;
        end else if (wr_ok) begin
            fill_end = wr_last_i || (32'(wptr_q) == DEPTH - 1);
            wptr_d   = wptr_q + PW'(1);
            if (fill_end) begin
                loaded_d = 1'b1;
                len_d    = LW'(wptr_q) + LW'(1);
            end
        end
    end

    // Control registers; reset leaves the block empty and unreadable.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            len_q    <= '0;
            loaded_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            len_q    <= len_d;
            loaded_q <= loaded_d;
        end
    end

    // Pixel storage; contents survive reset, len gates visibility.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

    // Read port returns zero outside the loaded length or the array.
    always_comb begin
        rd_data_o = '0;
        if (rd_en_i
            && (32'(rd_addr_i) < 32'(len_q))
            && (32'(rd_addr_i) < DEPTH)) begin
            rd_data_o = mem_q[rd_addr_i[PW-1:0]];
        end
    end

    assign loaded_o     = loaded_q;
    assign loaded_nxt_o = loaded_d;

endmodule

// File: rtl/sad_pixel_mem.sv
// Pixel-array responder for the sad core: loads blocks A/B, pulses go.
// Optional SAD_PIXMEM_REG_RD_EN registers A_data/B_data (1-cycle latency).
module sad_pixel_mem
    import sad_pkg::*;
#(
    parameter int DATA_W = SAD_PIX_W,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = SAD_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_sel,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              AB_rd,
    input  logic [ADDR_W-1:0] AB_addr,
    output logic [DATA_W-1:0] A_data,
    output logic [DATA_W-1:0] B_data,
    output logic              go,
    input  logic              sad_done,
    output logic [1:0]        loaded
);

    sad_mem_state_t    state_q, state_d;
    logic              accept;
    logic              wr_a, wr_b;
    logic              clr;
    logic              rd_en;
    logic [1:0]        loaded_nxt;
    logic [DATA_W-1:0] a_rd, b_rd;

    // Next state plus handshake, go and release decode.
    always_comb begin
        state_d  = state_q;
        ld_ready = 1'b0;
        go       = 1'b0;
        clr      = 1'b0;
        rd_en    = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                ld_ready = !loaded[ld_sel];
                if (&loaded_nxt) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                go      = 1'b1;
                state_d = S_SERVE;
            end
            S_SERVE: begin
                rd_en = AB_rd;
                if (sad_done) begin
                    clr     = 1'b1;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    assign accept = ld_valid && ld_ready;
    assign wr_a   = accept && !ld_sel;
    assign wr_b   = accept && ld_sel;

    sad_pix_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_bank_a (
        .clk          (clk),
        .rst          (rst),
        .wr_en_i      (wr_a),
        .wr_data_i    (ld_data),
        .wr_last_i    (ld_last),
        .clr_i        (clr),
        .rd_en_i      (rd_en),
        .rd_addr_i    (AB_addr),
        .rd_data_o    (a_rd),
        .loaded_o     (loaded[0]),
        .loaded_nxt_o (loaded_nxt[0])
    );

    sad_pix_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_bank_b (
        .clk          (clk),
        .rst          (rst),
        .wr_en_i      (wr_b),
        .wr_data_i    (ld_data),
        .wr_last_i    (ld_last),
        .clr_i        (clr),
        .rd_en_i      (rd_en),
        .rd_addr_i    (AB_addr),
        .rd_data_o    (b_rd),
        .loaded_o     (loaded[1]),
        .loaded_nxt_o (loaded_nxt[1])
    );

`ifdef SAD_PIXMEM_REG_RD_EN
    logic [DATA_W-1:0] a_q, b_q;

    // Registered read data; a cycle without AB_rd captures zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_rd;
            b_q <= b_rd;
        end
    end

    assign A_data = a_q;
    assign B_data = b_q;
`else
    assign A_data = a_rd;
    assign B_data = b_rd;
`endif

endmodule

// File: tb/tb_sad_pixel_mem.sv
// Self-checking bench for sad_pixel_mem: lockstep reference model,
// table-driven read vectors and directed load/serve sequences.
module tb_sad_pixel_mem;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld_valid;
    logic       ld_ready;
    logic       ld_sel;
    logic [8:0] ld_data;
    logic       ld_last;
    logic       AB_rd;
    logic [8:0] AB_addr;
    logic [8:0] A_data;
    logic [8:0] B_data;
    logic       go;
    logic       sad_done;
    logic [1:0] loaded;

    always #5 clk = ~clk;

    sad_pixel_mem dut (
        .clk      (clk),
        .rst      (rst),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_sel   (ld_sel),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .AB_rd    (AB_rd),
        .AB_addr  (AB_addr),
        .A_data   (A_data),
        .B_data   (B_data),
        .go       (go),
        .sad_done (sad_done),
        .loaded   (loaded)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: phase 0 = loading, 1 = go cycle, 2 = serving.
    int mem_m [2][256];
    int ptr_m [2];
    int len_m [2];
    bit ld_m  [2];
    int phase_m;
    int regA_m, regB_m;
    int go_seen;
    int sA, sB;
    int bq [256];

    function automatic int rd_m(int b, bit r, int a);
        if (phase_m != 2 || !r || a >= len_m[b] || a >= 256) return 0;
        return mem_m[b][a];
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            ptr_m[b] = 0;
            len_m[b] = 0;
            ld_m[b]  = 1'b0;
        end
        phase_m = 0;
        regA_m  = 0;
        regB_m  = 0;
    endtask

    // One clock: drive, compare against the model, advance the model.
    task automatic step(bit v, bit s, int d, bit l,
                        bit r, int a, bit dn, bit rs);
        int ca, cb, ea, eb;
        bit rdy;
        ld_valid = v;
        ld_sel   = s;
        ld_data  = 9'(d);
        ld_last  = l;
        AB_rd    = r;
        AB_addr  = 9'(a);
        sad_done = dn;
        rst      = rs;
        #1;
        ca = rd_m(0, r, a);
        cb = rd_m(1, r, a);
`ifdef SAD_PIXMEM_REG_RD_EN
        ea = regA_m;
        eb = regB_m;
`else
        ea = ca;
        eb = cb;
`endif
        rdy = (phase_m == 0) && !ld_m[s];
        chk("ld_ready", int'(ld_ready), int'(rdy));
        chk("go", int'(go), int'(phase_m == 1));
        chk("loaded", int'(loaded), int'({ld_m[1], ld_m[0]}));
        chk("A_data", int'(A_data), ea);
        chk("B_data", int'(B_data), eb);
        sA = int'(A_data);
        sB = int'(B_data);
        if (go) go_seen++;
        if (rs) begin
            model_reset();
        end else begin
            regA_m = ca;
            regB_m = cb;
            if (phase_m == 0) begin
                if (v && rdy) begin
                    mem_m[s][ptr_m[s]] = d & 511;
                    if (l || ptr_m[s] == 255) begin
                        ld_m[s]  = 1'b1;
                        len_m[s] = ptr_m[s] + 1;
                    end
                    ptr_m[s]++;
                end
                if (ld_m[0] && ld_m[1]) phase_m = 1;
            end else if (phase_m == 1) begin
                phase_m = 2;
            end else if (dn) begin
                for (int b = 0; b < 2; b++) begin
                    ptr_m[b] = 0;
                    len_m[b] = 0;
                    ld_m[b]  = 1'b0;
                end
                phase_m = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Read one address; sA/sB hold the data belonging to that read.
    task automatic rd_at(int a);
        step(0, 0, 0, 0, 1, a, 0, 0);
`ifdef SAD_PIXMEM_REG_RD_EN
        step(0, 0, 0, 0, 0, 0, 0, 0);
`endif
    endtask

    typedef struct {
        bit rd;
        int addr;
        int ea;
        int eb;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{1'b1, 0, 0, 255};
        tbl[1] = '{1'b1, 1, 1, 254};
        tbl[2] = '{1'b1, 127, 127, 128};
        tbl[3] = '{1'b1, 255, 255, 0};
        tbl[4] = '{1'b1, 256, 0, 0};
        tbl[5] = '{1'b1, 300, 0, 0};
        tbl[6] = '{1'b0, 5, 0, 0};
        tbl[7] = '{1'b1, 511, 0, 0};

        rst = 1'b1;
        ld_valid = 0; ld_sel = 0; ld_data = 0; ld_last = 0;
        AB_rd = 0; AB_addr = 0; sad_done = 0;
        model_reset();
        go_seen = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values.
        idle(1);
        chk("rst_ready", int'(ld_ready), 1);

        // Interleaved full load: A = i, B = 255 - i.
        go_seen = 0;
        for (int i = 0; i < 256; i++) begin
            step(1, 0, i, 0, 0, 0, 0, 0);
            step(1, 1, 255 - i, 0, 0, 0, 0, 0);
        end
        chk("loaded_full", int'(loaded), 3);
        chk("go_now", int'(go), 1);
        idle(3);
        chk("go_count", go_seen, 1);
        chk("ready_serve", int'(ld_ready), 0);

        // Table-driven reads.
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].rd) begin
                rd_at(tbl[i].addr);
            end else begin
                step(0, 0, 0, 0, 0, tbl[i].addr, 0, 0);
`ifdef SAD_PIXMEM_REG_RD_EN
                idle(1);
`endif
            end
            chk("tbl_A", sA, tbl[i].ea);
            chk("tbl_B", sB, tbl[i].eb);
        end

        // Sweep and random reads, model-checked.
        for (int a = 0; a < 256; a++) step(0, 0, 0, 0, 1, a, 0, 0);
        for (int i = 0; i < 40; i++)
            step(0, 0, 0, 0, 1'($urandom), int'($urandom_range(0, 511)), 0, 0);

        // Release with a read in the same cycle.
        step(0, 0, 0, 0, 1, 7, 1, 0);
`ifndef SAD_PIXMEM_REG_RD_EN
        chk("done_rd_A", sA, 7);
`endif
        step(0, 0, 0, 0, 1, 7, 0, 0);
        chk("done_loaded", int'(loaded), 0);
        chk("done_ready", int'(ld_ready), 1);

        // Short A block, stall on A, then full random B.
        step(1, 0, 100, 0, 0, 0, 0, 0);
        step(1, 0, 40, 0, 0, 0, 0, 0);
        step(1, 0, 'h1FE, 1, 0, 0, 0, 0);
        step(1, 0, 77, 0, 0, 0, 0, 0);
        chk("stall_ready", int'(ld_ready), 0);
        step(1, 0, 78, 1, 0, 0, 0, 0);
        go_seen = 0;
        for (int i = 0; i < 256; i++) begin
            bq[i] = int'($urandom_range(0, 511));
            step(1, 1, bq[i], 0, 0, 0, 0, 0);
        end
        idle(2);
        chk("go_count2", go_seen, 1);
        rd_at(0);
        chk("short_A0", sA, 100);
        chk("short_B0", sB, bq[0]);
        rd_at(2);
        chk("short_A2", sA, 'h1FE);
        rd_at(3);
        chk("short_A3", sA, 0);
        chk("short_B3", sB, bq[3]);
        step(0, 0, 0, 0, 0, 0, 1, 0);

        // Randomized traffic including stray sad_done and resets.
        for (int i = 0; i < 1500; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom),
                 int'($urandom_range(0, 511)),
                 $urandom_range(0, 47) == 0, 1'($urandom),
                 int'($urandom_range(0, 299)),
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 599) == 0);

        // Reset mid-load, then a fresh full load from index 0.
        step(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(1, 0, 50 + i, 0, 0, 0, 0, 0);
        step(1, 0, 60, 0, 0, 0, 0, 1);
        chk("mid_rst_loaded", int'(loaded), 0);
        chk("mid_rst_ready", int'(ld_ready), 1);
        chk("mid_rst_A", int'(A_data), 0);
        for (int i = 0; i < 256; i++) begin
            step(1, 0, i + 3, 0, 0, 0, 0, 0);
            step(1, 1, (i * 5) & 511, 0, 0, 0, 0, 0);
        end
        idle(2);
        rd_at(0);
        chk("reload_A0", sA, 3);
        chk("reload_B0", sB, 0);
        rd_at(100);
        chk("reload_A100", sA, 103);
        chk("reload_B100", sB, 500);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
